// File: rtl/ssp_pkg.sv
// Shared types and width helpers for the parametrised synchronous serial port.
// Latency: none (types and constant functions only).
// Backpressure: none.
package ssp_pkg;

    // Transmit sequencer states
    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_e;

    // Bit counter width: must hold the values 0..data_w
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // FIFO pointer width; pointers wrap naturally at a power-of-two depth
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Generic synchronous FIFO with registered occupancy and combinational head.
// Latency: a pushed word is visible on head_o one edge after the push when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; push and pop may coincide.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);
    localparam int PW = ptr_w(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       count_q;
    logic              push_eff;
    logic              pop_eff;

    assign full_o   = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty_o  = (count_q == '0);
    assign head_o   = mem_q[rd_ptr_q];
    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ssp_param.sv
// Parametrised SSP: host-fed TX FIFO into framed serial shifter, serial receiver into RX FIFO.
// Latency: TX pop to RX push is CLK_DIV*DATA_W + CLK_DIV/2 + 1 PCLK edges over loopback.
// Backpressure: full TX FIFO drops host pushes; full RX FIFO drops received words (flagged when SSP_OVERRUN_EN is defined).
module ssp_param
    import ssp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              SSPTXINTR,
    output logic              SSPRXINTR
`ifdef SSP_OVERRUN_EN
    ,
    output logic              SSPRORINTR
`endif
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] BIT_DONE = CNT_W'(DATA_W);

    // ---------------- serial clock divider ----------------
    logic [DIV_W-1:0] div_q;
    logic             sclk_q;
    logic             tick;

    // A tick is the PCLK edge on which SSPCLKOUT rises
    assign tick = (div_q == DIV_LAST) & ~sclk_q;

    // Free-running half-period counter toggling the serial clock
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    // ---------------- FIFOs ----------------
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [DATA_W-1:0] rx_sh_d;

    assign rx_pop = PSEL & ~PWRITE;

    ssp_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i      (PCLK),
        .rst_i      (CLEAR),
        .push_i     (PSEL & PWRITE),
        .push_dat_i (PWDATA),
        .pop_i      (tx_pop),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .head_o     (tx_head)
    );

    ssp_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i      (PCLK),
        .rst_i      (CLEAR),
        .push_i     (rx_push),
        .push_dat_i (rx_sh_d),
        .pop_i      (rx_pop),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .head_o     (rx_head)
    );

    assign PRDATA    = rx_empty ? '0 : rx_head;
    assign SSPTXINTR = tx_full;
    assign SSPRXINTR = rx_full;

    // ---------------- transmitter ----------------
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              fss_q, fss_d;
    logic              txd_q, txd_d;
    logic              oe_b_q, oe_b_d;

    // Transmit sequencing: all output changes happen on ticks only
    always_comb begin
        state_d  = state_q;
        tx_sh_d  = tx_sh_q;
        tx_cnt_d = tx_cnt_q;
        fss_d    = fss_q;
        txd_d    = txd_q;
        oe_b_d   = oe_b_q;
        tx_pop   = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_pop   = 1'b1;
                        tx_sh_d  = tx_head;
                        tx_cnt_d = '0;
                        fss_d    = 1'b1;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (tx_cnt_q == BIT_DONE) begin
                        // Period after the last bit with no follow-on word
                        state_d = IDLE;
                        fss_d   = 1'b0;
                        txd_d   = 1'b0;
                        oe_b_d  = 1'b1;
                    end else begin
                        txd_d    = (MSB_FIRST != 0) ? tx_sh_q[DATA_W-1] : tx_sh_q[0];
                        tx_sh_d  = (MSB_FIRST != 0) ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                                    : {1'b0, tx_sh_q[DATA_W-1:1]};
                        tx_cnt_d = tx_cnt_q + 1'b1;
                        fss_d    = 1'b0;
                        oe_b_d   = 1'b0;
                        // Back-to-back: frame sync for the next word overlaps the last bit
                        if ((tx_cnt_q == BIT_LAST) && !tx_empty) begin
                            tx_pop   = 1'b1;
                            tx_sh_d  = tx_head;
                            tx_cnt_d = '0;
                            fss_d    = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Transmit state registers
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q  <= IDLE;
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
            fss_q    <= 1'b0;
            txd_q    <= 1'b0;
            oe_b_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            tx_sh_q  <= tx_sh_d;
            tx_cnt_q <= tx_cnt_d;
            fss_q    <= fss_d;
            txd_q    <= txd_d;
            oe_b_q   <= oe_b_d;
        end
    end

    assign SSPCLKOUT = sclk_q;
    assign SSPFSSOUT = fss_q;
    assign SSPTXD    = txd_q;
    assign SSPOE_B   = oe_b_q;

    // ---------------- receiver ----------------
    logic              clkin_q;
    logic              rx_fall;
    logic              rx_armed_q, rx_armed_d;
    logic [DATA_W-1:0] rx_sh_q;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;

    assign rx_fall = clkin_q & ~SSPCLKIN;

    // Receive shifting on each falling receive clock; frame sync re-arms after the shift
    always_comb begin
        rx_armed_d = rx_armed_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_push    = 1'b0;
        if (rx_fall) begin
            if (rx_armed_q) begin
                rx_sh_d  = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], SSPRXD}
                                            : {SSPRXD, rx_sh_q[DATA_W-1:1]};
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == BIT_LAST) begin
                    rx_push    = 1'b1;
                    rx_armed_d = 1'b0;
                end
            end
            if (SSPFSSIN) begin
                rx_armed_d = 1'b1;
                rx_cnt_d   = '0;
            end
        end
    end

    // Receive state registers and receive clock edge history
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            clkin_q    <= 1'b0;
            rx_armed_q <= 1'b0;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            clkin_q    <= SSPCLKIN;
            rx_armed_q <= rx_armed_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

`ifdef SSP_OVERRUN_EN
    logic ror_q;

    // Sticky overrun: a drop wins over a same-edge clearing pop
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            ror_q <= 1'b0;
        end else if (rx_push && rx_full) begin
            ror_q <= 1'b1;
        end else if (rx_pop && !rx_empty) begin
            ror_q <= 1'b0;
        end
    end

    assign SSPRORINTR = ror_q;
`endif

endmodule
